jtsdram_bank_chk: RTL and testbench

Per-bank read checker answering the test sequencer's read-start request. On `rd_start` it walks a key-selected address window of one SDRAM bank through the controller's read port and compares each returned word against a counter pattern seeded by `data_ref`. It then holds `done` high with pass/fail status until the next start. Four instances, one per bank, sit between the sequencer and the SDRAM controller.

---
 rtl/jtsdram_pkg.sv | 16 +
 rtl/jtsdram_pattern.sv | 14 +
 rtl/jtsdram_bank_chk.sv | 169 ++++++++++++++++
 tb/tb_jtsdram_bank_chk.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank programmer and checker blocks.
// State encoding is common to both so the sequencer can decode either one.
package jtsdram_pkg;

  // Width of the bank key that selects the address window
  localparam int KEYW = 5;

  // Pass states shared with the programmer block
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/jtsdram_pattern.sv
// Expected-word generator: seed plus zero-extended word index, modulo 2^16.
// Shared with the programmer so written and checked data always agree.
module jtsdram_pattern #(
  parameter int CNTW = 8
) (
  input  logic [15:0]     data_ref,
  input  logic [CNTW-1:0] idx,
  output logic [15:0]     word
);

  // Pure combinational sum; the 16-bit result wraps naturally
  assign word = data_ref + 16'(idx);

endmodule

// File: rtl/jtsdram_bank_chk.sv
// Per-bank read checker. On rd_start it reads 2^CNTW words from the window
// {key, zeros, idx} through the controller read port, compares each word with
// the counter pattern seeded by data_ref, and then holds done with the result.
// Optional macro JTSDRAM_TIMEOUT_EN adds a watchdog that aborts a stuck pass
// after TOUT cycles in REQ or WAIT and flags it as bad.
module jtsdram_bank_chk
  import jtsdram_pkg::*;
#(
  parameter int AW   = 22,
  parameter int CNTW = 8,
  parameter int TOUT = 1023
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          rd_start,
  input  logic [4:0]    key,
  input  logic [15:0]   data_ref,
  output logic          done,
  output logic          bad,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] bad_addr,
  output logic          ba_rd,
  output logic [AW-1:0] ba_addr,
  input  logic          ba_ack,
  input  logic          ba_rdy,
  input  logic [15:0]   data_read
);

  // Reject parameter sets the address layout or the watchdog cannot hold
  if (AW < KEYW + CNTW || TOUT < 1 || TOUT > 65535) begin : g_bad_param
    $error("jtsdram_bank_chk: AW must be >= 5+CNTW and TOUT within 1..65535");
  end

  state_t          state;
  logic [KEYW-1:0] key_l;
  logic [15:0]     ref_l;
  logic [CNTW-1:0] idx;
  logic [15:0]     exp_word;
  logic            take_data;
  logic            mismatch;
  logic            last_word;

  // Window address: key in the top bits, word index in the bottom bits
  function automatic logic [AW-1:0] word_addr(input logic [KEYW-1:0] k,
                                              input logic [CNTW-1:0] i);
    logic [AW-1:0] a;
    a = '0;
    a[AW-1 -: KEYW] = k;
    a[CNTW-1:0]     = i;
    return a;
  endfunction

  jtsdram_pattern #(.CNTW(CNTW)) u_pattern (
    .data_ref (ref_l),
    .idx      (idx),
    .word     (exp_word)
  );

  // Data is taken in WAIT, or in REQ when ack and rdy coincide
  assign take_data = ba_rdy && (state == ST_WAIT || (state == ST_REQ && ba_ack));
  assign mismatch  = data_read != exp_word;
  assign last_word = &idx;

`ifdef JTSDRAM_TIMEOUT_EN
  logic [15:0] wdog;
  logic        wdog_hit;

  // Fires on the cycle the watchdog would reach TOUT
  assign wdog_hit = (wdog + 16'd1) == 16'(TOUT);
`endif

  // Pass sequencer: request/wait handshake, result capture and done flag
  always_ff @(posedge clk) begin
    // NOTE: every register, including the latched key/seed, is reset so a
    // mid-pass reset leaves nothing from the aborted pass behind.
    if (rst) begin
      state    <= ST_IDLE;
      key_l    <= '0;
      ref_l    <= '0;
      idx      <= '0;
      done     <= 1'b0;
      bad      <= 1'b0;
      err_cnt  <= '0;
      bad_addr <= '0;
      ba_rd    <= 1'b0;
      ba_addr  <= '0;
`ifdef JTSDRAM_TIMEOUT_EN
      wdog     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so later statements in
      // this block override earlier ones without read-after-write hazards.
      case (state)
        ST_IDLE, ST_DONE: begin
          if (rd_start) begin
            state    <= ST_REQ;
            key_l    <= key;
            ref_l    <= data_ref;
            idx      <= '0;
            done     <= 1'b0;
            bad      <= 1'b0;
            err_cnt  <= '0;
            bad_addr <= '0;
            ba_rd    <= 1'b1;
            ba_addr  <= word_addr(key, '0);
`ifdef JTSDRAM_TIMEOUT_EN
            wdog     <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (ba_ack) begin
            ba_rd <= 1'b0;
            state <= ST_WAIT;
`ifdef JTSDRAM_TIMEOUT_EN
            wdog  <= '0;
          end else if (wdog_hit) begin
            bad   <= 1'b1;
            if (!bad) bad_addr <= ba_addr;
            ba_rd <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            wdog  <= wdog + 16'd1;
`endif
          end
        end
        ST_WAIT: begin
`ifdef JTSDRAM_TIMEOUT_EN
          if (!ba_rdy) begin
            if (wdog_hit) begin
              bad   <= 1'b1;
              if (!bad) bad_addr <= ba_addr;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              wdog  <= wdog + 16'd1;
            end
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase

      // A returned word overrides the REQ/WAIT moves above
      if (take_data) begin
        if (mismatch) begin
          bad <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (!bad) bad_addr <= ba_addr;
        end
        if (last_word) begin
          state <= ST_DONE;
          done  <= 1'b1;
          ba_rd <= 1'b0;
        end else begin
          state   <= ST_REQ;
          idx     <= idx + CNTW'(1);
          ba_rd   <= 1'b1;
          ba_addr <= word_addr(key_l, idx + CNTW'(1));
`ifdef JTSDRAM_TIMEOUT_EN
          wdog    <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// Self-checking bench for jtsdram_bank_chk: a behavioural SDRAM read port
// returns seed+index words (optionally corrupted) with configurable or random
// ack/rdy latencies; pass results are predicted from the pattern rules.
module tb_jtsdram_bank_chk;

  localparam int AW   = 22;
  localparam int CNTW = 8;
  localparam int TOUT = 1023;
  localparam int NW   = 1 << CNTW;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_start;
  logic          rd_start_m = 1'b0;
  logic          inj_start = 1'b0;
  logic [4:0]    key = '0;
  logic [15:0]   data_ref = '0;
  logic          done, bad;
  logic [7:0]    err_cnt;
  logic [AW-1:0] bad_addr, ba_addr;
  logic          ba_rd;
  logic          ba_ack = 1'b0;
  logic          ba_rdy = 1'b0;
  logic [15:0]   data_read = '0;

  assign rd_start = rd_start_m | inj_start;

  jtsdram_bank_chk #(.AW(AW), .CNTW(CNTW), .TOUT(TOUT)) dut (
    .rst(rst), .clk(clk), .rd_start(rd_start), .key(key), .data_ref(data_ref),
    .done(done), .bad(bad), .err_cnt(err_cnt), .bad_addr(bad_addr),
    .ba_rd(ba_rd), .ba_addr(ba_addr), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .data_read(data_read)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Responder configuration (written by the main sequence only)
  logic [15:0] cur_ref = '0;
  int  cmode    = 0;      // 0 clean, 1 one corrupted index, 2 all corrupted
  int  c_idx    = 0;
  int  ack_lat  = 0;
  int  rdy_lat  = 0;
  bit  rand_lat = 0;
  bit  same_cyc = 0;
  bit  inj_en   = 0;
  bit  no_rdy   = 0;

  // Responder observations (written by the responder only)
  logic [AW-1:0] addr_q[$];
  int  ovl     = 0;
  int  ack_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k, input int i);
    return 32'(k) * 32'(1 << (AW - 5)) + 32'(i);
  endfunction

  // Memory model: word at index i is seed+i mod 2^16, flipped when corrupted
  function automatic logic [15:0] model_word(input logic [AW-1:0] a);
    int i;
    logic [15:0] w;
    i = int'(a) % NW;
    w = 16'((int'(cur_ref) + i) % 65536);
    if (cmode == 2 || (cmode == 1 && i == c_idx)) w = w ^ 16'h00FF;
    return w;
  endfunction

  // Controller read port model, driven on negative edges
  initial begin
    int phase = 0;
    int cnt   = 0;
    logic [AW-1:0] cur_a = '0;
    forever begin
      @(negedge clk);
      ba_ack = 1'b0;
      ba_rdy = 1'b0;
      inj_start = 1'b0;
      if (phase == 2 && ba_rd === 1'b1) ovl++;
      if (phase == 0 && ba_rd === 1'b1) begin
        phase = 1;
        cnt = rand_lat ? int'($urandom_range(20, 0)) : ack_lat;
      end
      if (phase == 1) begin
        if (cnt == 0) begin
          ba_ack  = 1'b1;
          ack_cyc = cyc;
          cur_a   = ba_addr;
          addr_q.push_back(ba_addr);
          if (same_cyc) begin
            ba_rdy = 1'b1;
            data_read = model_word(cur_a);
            phase = 0;
          end else begin
            phase = 2;
            cnt = rand_lat ? int'($urandom_range(20, 1)) : rdy_lat;
          end
        end else cnt--;
      end else if (phase == 2) begin
        if (cnt != 0) begin
          if (inj_en && cnt == 3) inj_start = 1'b1;
          cnt--;
        end else if (!no_rdy) begin
          ba_rdy = 1'b1;
          data_read = model_word(cur_a);
          phase = 0;
        end
      end
    end
  end

  task automatic start_pass(input logic [4:0] k, input logic [15:0] r,
                            output int start_c, output int base, output int ovl0);
    cur_ref = r;
    base = addr_q.size();
    ovl0 = ovl;
    @(negedge clk);
    key = k; data_ref = r; rd_start_m = 1'b1; start_c = cyc;
    @(negedge clk);
    rd_start_m = 1'b0;
    key = 5'($urandom); data_ref = 16'($urandom);
    check("done_falls_after_start", {31'd0, done}, 32'd1 - 32'd1);
    check("ba_rd_rises_after_start", {31'd0, ba_rd}, 32'd1);
  endtask

  task automatic wait_done(output int done_c);
    int n = 0;
    while (done !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    done_c = cyc;
    check("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [4:0] k, input int mode,
                              input int cidx, input int base, input int ovl0);
    int exp_err, bad_seq, reqs;
    logic [31:0] exp_ba;
    exp_err = (mode == 0) ? 0 : (mode == 1) ? 1 : (NW > 255 ? 255 : NW);
    exp_ba  = (mode == 0) ? 32'd0 : exp_addr(int'(k), (mode == 1) ? cidx : 0);
    reqs = addr_q.size() - base;
    bad_seq = 0;
    for (int i = 0; i < NW; i++)
      if (base + i >= addr_q.size() || 32'(addr_q[base + i]) !== exp_addr(int'(k), i))
        bad_seq++;
    check({tag, "_bad"}, {31'd0, bad}, (mode != 0) ? 32'd1 : 32'd0);
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'(exp_err));
    check({tag, "_bad_addr"}, 32'(bad_addr), exp_ba);
    check({tag, "_req_count"}, 32'(reqs), 32'(NW));
    check({tag, "_addr_seq"}, 32'(bad_seq), 32'd0);
    check({tag, "_outstanding"}, 32'(ovl - ovl0), 32'd0);
  endtask

  initial begin
    int s_c, d_c, base, ovl0, n, cidx;
    logic [4:0]  k;
    logic [15:0] r;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bad", {31'd0, bad}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_bad_addr", 32'(bad_addr), 32'd0);
    check("rst_ba_rd", {31'd0, ba_rd}, 32'd0);
    check("rst_ba_addr", 32'(ba_addr), 32'd0);

    // Clean pass, zero-latency ack and one-cycle rdy: minimum pass length
    cmode = 0; ack_lat = 0; rdy_lat = 0;
    start_pass(5'h0A, 16'h1234, s_c, base, ovl0);
    wait_done(d_c);
    check("clean_pass_length", 32'(d_c - s_c), 32'(2 * NW + 1));
    check_result("clean", 5'h0A, 0, 0, base, ovl0);

    // Single corrupted word at index 0x37
    cmode = 1; c_idx = 'h37; rdy_lat = 1;
    start_pass(5'h0A, 16'h1234, s_c, base, ovl0);
    wait_done(d_c);
    check_result("single", 5'h0A, 1, 'h37, base, ovl0);

    // Every word corrupted across the 16-bit wrap: counter saturates
    cmode = 2; rdy_lat = 0;
    start_pass(5'h0A, 16'hFFF0, s_c, base, ovl0);
    wait_done(d_c);
    check_result("saturate", 5'h0A, 2, 0, base, ovl0);

    // Same seed, clean model: the wrap itself is not an error
    cmode = 0;
    start_pass(5'h0A, 16'hFFF0, s_c, base, ovl0);
    wait_done(d_c);
    check_result("wrap_clean", 5'h0A, 0, 0, base, ovl0);

    // Ack and rdy in the same cycle, random key and seed
    same_cyc = 1;
    k = 5'($urandom); r = 16'($urandom);
    start_pass(k, r, s_c, base, ovl0);
    wait_done(d_c);
    check_result("same_cycle", k, 0, 0, base, ovl0);
    same_cyc = 0;

    // Random latencies, one random corrupted word, starts pulsed during WAIT
    rand_lat = 1; inj_en = 1; cmode = 1;
    cidx = int'($urandom_range(NW - 1, 0)); c_idx = cidx;
    k = 5'($urandom); r = 16'($urandom);
    start_pass(k, r, s_c, base, ovl0);
    wait_done(d_c);
    inj_en = 0; rand_lat = 0;
    check_result("random_lat", k, 1, cidx, base, ovl0);

    // Reset while requesting index 100; late ack/rdy must be ignored
    cmode = 2; ack_lat = 10; rdy_lat = 0;
    start_pass(5'h15, 16'h0F0F, s_c, base, ovl0);
    n = 0;
    while (!(ba_rd === 1'b1 && ba_addr[CNTW-1:0] == CNTW'(100)) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("midpass_reached_idx100", {31'd0, ba_rd}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midpass_ba_rd", {31'd0, ba_rd}, 32'd0);
    check("midpass_bad", {31'd0, bad}, 32'd0);
    check("midpass_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("midpass_bad_addr", 32'(bad_addr), 32'd0);
    check("midpass_ba_addr", 32'(ba_addr), 32'd0);
    repeat (40) @(negedge clk);
    check("late_resp_ba_rd", {31'd0, ba_rd}, 32'd0);
    check("late_resp_done", {31'd0, done}, 32'd0);
    check("late_resp_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Recovery pass after the aborted one
    cmode = 0; ack_lat = 0;
    start_pass(5'h1F, 16'hA5A5, s_c, base, ovl0);
    wait_done(d_c);
    check_result("recover", 5'h1F, 0, 0, base, ovl0);

`ifdef JTSDRAM_TIMEOUT_EN
    // Read port that never returns data: watchdog ends the pass
    no_rdy = 1;
    start_pass(5'h03, 16'h0000, s_c, base, ovl0);
    wait_done(d_c);
    check("timeout_latency", 32'(d_c - ack_cyc), 32'(TOUT + 1));
    check("timeout_bad", {31'd0, bad}, 32'd1);
    check("timeout_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("timeout_bad_addr", 32'(bad_addr), exp_addr(3, 0));
    check("timeout_ba_rd", {31'd0, ba_rd}, 32'd0);
    no_rdy = 0;
    repeat (5) @(negedge clk);
    check("timeout_done_held", {31'd0, done}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
